// File: rtl/pll_lock_ctrl.sv
// Lock supervisor for one or more PLL_B instances on the camera/pixel path.
// It sequences PLL reset, qualifies lock, recovers from lock loss and can bypass the PLLs on failure.
module pll_lock_ctrl #(
    parameter int NUM_PLL        = 2,
    parameter int DELAY_W        = 8,
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRY      = 3,
    parameter bit BYPASS_ON_FAIL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_PLL*DELAY_W-1:0] delay_in,
    input  logic                       delay_upd,
    input  logic [NUM_PLL-1:0]         pll_lock,
    output logic [NUM_PLL-1:0]         pll_reset_n,
    output logic [NUM_PLL*DELAY_W-1:0] pll_dyndelay,
    output logic                       pll_bypass,
    output logic                       ready,
    output logic                       fail,
    output logic                       lost_lock,
    output logic [1:0]                 retry_cnt,
    output logic [2:0]                 state_o
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] ST_LAST    = SW'(STABLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_LAST = 2'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STABLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t state, nxt;

    logic [NUM_PLL-1:0] lock_meta, lock_sync;
    logic               all_lock;
    logic [HW-1:0]      hold_cnt;
    logic [TW-1:0]      to_cnt;
    logic [SW-1:0]      st_cnt;
    logic               latch_dly, clr_retry, inc_retry, loss;
    logic               rel_n;

    // LOCK is asynchronous to clk; two flops per bit before any use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    assign all_lock = &lock_sync;

    always_comb begin
        nxt       = state;
        latch_dly = 1'b0;
        clr_retry = 1'b0;
        inc_retry = 1'b0;
        loss      = 1'b0;
        unique case (state)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    nxt       = S_HOLD;
                    latch_dly = 1'b1;
                    clr_retry = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST)
                    nxt = S_WAIT;
            end
            S_WAIT: begin
                if (all_lock) begin
                    nxt = S_STABLE;
                end else if (to_cnt == TO_LAST) begin
                    inc_retry = 1'b1;
                    nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_HOLD;
                end
            end
            S_STABLE: begin
                if (!all_lock)
                    nxt = S_WAIT;
                else if (st_cnt == ST_LAST)
                    nxt = S_RUN;
            end
            S_RUN: begin
                // lock loss outranks a delay update, but the delay still lands
                if (!all_lock) begin
                    nxt       = S_HOLD;
                    loss      = 1'b1;
                    clr_retry = 1'b1;
                    latch_dly = delay_upd;
                end else if (delay_upd) begin
                    nxt       = S_HOLD;
                    latch_dly = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign rel_n = (nxt == S_WAIT) || (nxt == S_STABLE) || (nxt == S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            to_cnt       <= '0;
            st_cnt       <= '0;
            retry_cnt    <= 2'd0;
            pll_reset_n  <= '0;
            pll_dyndelay <= '0;
            pll_bypass   <= 1'b0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            lost_lock    <= 1'b0;
        end else begin
            state    <= nxt;
            hold_cnt <= (state == S_HOLD)   ? hold_cnt + 1'b1 : '0;
            to_cnt   <= (state == S_WAIT)   ? to_cnt + 1'b1   : '0;
            st_cnt   <= (state == S_STABLE) ? st_cnt + 1'b1   : '0;
            if (clr_retry)
                retry_cnt <= 2'd0;
            else if (inc_retry && retry_cnt != 2'd3)
                retry_cnt <= retry_cnt + 2'd1;
            // outputs follow the next state so the PLL pins change cleanly
            pll_reset_n <= {NUM_PLL{rel_n}};
            pll_bypass  <= BYPASS_ON_FAIL && (nxt == S_FAIL);
            ready       <= (nxt == S_RUN);
            fail        <= (nxt == S_FAIL);
            lost_lock   <= loss;
            if (latch_dly)
                pll_dyndelay <= delay_in;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with short reset/timeout/stable windows.
// Covers lock, timeout-to-fail, lock loss, delay updates, stability glitches and async reset.
module tb_pll_lock_ctrl;

    localparam int NP = 2;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             delay_upd = 1'b0;
    logic [NP*DW-1:0] delay_in = '0;
    logic [NP-1:0]    pll_lock = '0;
    logic [NP-1:0]    pll_reset_n;
    logic [NP*DW-1:0] pll_dyndelay;
    logic             pll_bypass;
    logic             ready;
    logic             fail;
    logic             lost_lock;
    logic [1:0]       retry_cnt;
    logic [2:0]       state_o;

    int passed = 0;
    int total  = 0;
    int n;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .NUM_PLL       (NP),
        .DELAY_W       (DW),
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .BYPASS_ON_FAIL(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .delay_in    (delay_in),
        .delay_upd   (delay_upd),
        .pll_lock    (pll_lock),
        .pll_reset_n (pll_reset_n),
        .pll_dyndelay(pll_dyndelay),
        .pll_bypass  (pll_bypass),
        .ready       (ready),
        .fail        (fail),
        .lost_lock   (lost_lock),
        .retry_cnt   (retry_cnt),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s,
                              input int max);
        for (int i = 0; i < max && state_o !== s; i++)
            @(negedge clk);
        chk(tag, state_o, s);
    endtask

    task automatic wait_ready(input string tag, input int max);
        for (int i = 0; i < max && ready !== 1'b1; i++)
            @(negedge clk);
        chk(tag, ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " state"}, state_o, 0);
        chk({tag, " rstn"}, pll_reset_n, 0);
        chk({tag, " dly"}, pll_dyndelay, 0);
        chk({tag, " byp"}, pll_bypass, 0);
        chk({tag, " rdy"}, ready, 0);
        chk({tag, " fail"}, fail, 0);
        chk({tag, " lost"}, lost_lock, 0);
        chk({tag, " retry"}, retry_cnt, 0);
    endtask

    // start from IDLE; lock first sampled on the 10th edge after WAIT entry
    task automatic seq1(input string tag);
        int m;
        pll_lock = 2'b00;
        delay_in = 16'h2A15;
        start    = 1'b1;
        m = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pll_reset_n !== 2'b00) break;
            m++;
        end
        chk({tag, " hold_len"}, m, 4);
        chk({tag, " dly"}, pll_dyndelay, 16'h2A15);
        chk({tag, " wait"}, state_o, 2);
        cyc(9);
        pll_lock = 2'b11;
        m = 9;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            m++;
            if (ready) break;
        end
        chk({tag, " rdy_lat"}, m, 20);
        chk({tag, " rdy"}, ready, 1);
        chk({tag, " run"}, state_o, 4);
        chk({tag, " rstn"}, pll_reset_n, 2'b11);
        chk({tag, " retry"}, retry_cnt, 0);
    endtask

    initial begin
        #2 reset = 1'b1;
        #2 check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        seq1("s1");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("start_ign state", state_o, 4);
        chk("start_ign rdy", ready, 1);

        pll_lock = 2'b01;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            pll_lock = 2'b11;
            if (lost_lock) break;
        end
        chk("s3 lost_lat", n, 3);
        chk("s3 rdy", ready, 0);
        chk("s3 state", state_o, 1);
        chk("s3 retry", retry_cnt, 0);
        chk("s3 rstn", pll_reset_n, 2'b00);
        @(negedge clk);
        chk("s3 lost_pulse", lost_lock, 0);
        wait_ready("s3 relock", 40);

        delay_in  = 16'h0307;
        delay_upd = 1'b1;
        @(negedge clk);
        delay_upd = 1'b0;
        chk("s5 dly", pll_dyndelay, 16'h0307);
        chk("s5 rstn", pll_reset_n, 2'b00);
        chk("s5 lost", lost_lock, 0);
        chk("s5 rdy", ready, 0);
        chk("s5 state", state_o, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            @(negedge clk);
            n++;
        end
        chk("s5 requal", n, 13);

        pll_lock = 2'b10;
        @(negedge clk);
        pll_lock = 2'b11;
        @(negedge clk);
        delay_in  = 16'h5AC3;
        delay_upd = 1'b1;
        @(negedge clk);
        delay_upd = 1'b0;
        chk("s5b lost", lost_lock, 1);
        chk("s5b dly", pll_dyndelay, 16'h5AC3);
        chk("s5b state", state_o, 1);
        chk("s5b rdy", ready, 0);
        wait_ready("s5b relock", 40);

        delay_in  = 16'h1122;
        delay_upd = 1'b1;
        @(negedge clk);
        delay_upd = 1'b0;
        wait_state("s4 stable", 3, 20);
        cyc(3);
        pll_lock = 2'b10;
        cyc(1);
        pll_lock = 2'b11;
        cyc(1);
        chk("s4 still_stable", state_o, 3);
        cyc(1);
        chk("s4 back_wait", state_o, 2);
        chk("s4 rdy", ready, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            @(negedge clk);
            n++;
        end
        chk("s4 full_qual", n, 9);

        pll_lock = 2'b00;
        wait_state("s6 in_wait", 2, 30);
        #2 reset = 1'b1;
        #1 check_reset_vals("s6 rst_wait");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        pll_lock = 2'b01;
        delay_in = 16'hABCD;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state("s2 wait1", 2, 10);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (state_o !== 3'd2) break;
            n++;
            @(negedge clk);
        end
        chk("s2 to1_len", n, 32);
        chk("s2 to1_state", state_o, 1);
        chk("s2 retry1", retry_cnt, 1);
        delay_in  = 16'h1111;
        delay_upd = 1'b1;
        @(negedge clk);
        delay_upd = 1'b0;
        chk("s2 upd_ign", pll_dyndelay, 16'hABCD);
        wait_state("s2 wait2", 2, 10);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (state_o !== 3'd2) break;
            n++;
            @(negedge clk);
        end
        chk("s2 to2_len", n, 32);
        chk("s2 fail_state", state_o, 5);
        chk("s2 retry2", retry_cnt, 2);
        chk("s2 fail", fail, 1);
        chk("s2 byp", pll_bypass, 1);
        chk("s2 rstn", pll_reset_n, 2'b00);
        chk("s2 rdy", ready, 0);

        #2 reset = 1'b1;
        #1 check_reset_vals("s6 rst_fail");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        seq1("s6 restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
